// File: rtl/cp0_exc_unit.sv
// CP0 register file and exception/interrupt arbiter for the MEM stage.
// Optional timer (Count/Compare/TI) is built only when CP0_TIMER_EN is defined.
module cp0_exc_unit #(
  parameter int unsigned HW_INT_NUM = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            read_addr_i,
  input  logic                  write_en_i,
  input  logic [4:0]            write_addr_i,
  input  logic [31:0]           write_data_i,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  inst_valid_i,
  input  logic [6:0]            exc_flags_i,
  input  logic                  eret_i,
  input  logic                  delayslot_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           badaddr_i,
  output logic [31:0]           read_data_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned EW = 5;

  localparam logic [RW-1:0] REG_BADVADDR = RW'(8);
  localparam logic [RW-1:0] REG_COUNT    = RW'(9);
  localparam logic [RW-1:0] REG_COMPARE  = RW'(11);
  localparam logic [RW-1:0] REG_STATUS   = RW'(12);
  localparam logic [RW-1:0] REG_CAUSE    = RW'(13);
  localparam logic [RW-1:0] REG_EPC      = RW'(14);

  localparam logic [DW-1:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [DW-1:0] STATUS_WMASK = 32'h0040_FF03;

  localparam logic [EW-1:0] EC_INT  = EW'(0);
  localparam logic [EW-1:0] EC_ADEL = EW'(4);
  localparam logic [EW-1:0] EC_ADES = EW'(5);
  localparam logic [EW-1:0] EC_SYS  = EW'(8);
  localparam logic [EW-1:0] EC_BP   = EW'(9);
  localparam logic [EW-1:0] EC_RI   = EW'(10);
  localparam logic [EW-1:0] EC_OV   = EW'(12);

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_e;

  // Invalid configurations stop elaboration.
  if (COUNT_DIV < 1 || HW_INT_NUM < 1 || HW_INT_NUM > 6) begin : g_param_check
    $error("cp0_exc_unit: COUNT_DIV must be >= 1 and HW_INT_NUM in 1..6");
  end

  logic [DW-1:0] r_status;
  logic [DW-1:0] r_epc;
  logic [DW-1:0] r_badvaddr;
  logic          r_bd;
  logic [EW-1:0] r_exccode;
  logic [1:0]    r_ip_sw;
  logic [5:0]    r_ip_hw;

  logic [5:0]    w_hw_pad;
  logic [7:0]    w_ip;
  logic [DW-1:0] w_cause;
  logic          w_ti;
  logic [DW-1:0] w_count;
  logic [DW-1:0] w_compare;
  logic          w_int_req;
  logic          w_exc_take;
  logic          w_eret;
  logic          w_mtc0;
  logic [EW-1:0] w_exccode;
  bad_sel_e      w_bad_sel;

  assign w_hw_pad = 6'(hw_int_i);

  `ifdef CP0_TIMER_EN
  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DW-1:0] r_count;
  logic [DW-1:0] r_compare;
  logic [PW-1:0] r_presc;
  logic          r_ti;

  // Prescaled Count, Compare match and sticky timer flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_presc   <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (w_mtc0 && write_addr_i == REG_COUNT) begin
        r_count <= write_data_i;
        r_presc <= '0;
      end else if (r_presc == PW'(COUNT_DIV - 1)) begin
        r_presc <= '0;
        r_count <= r_count + DW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_mtc0 && write_addr_i == REG_COMPARE) begin
        r_compare <= write_data_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare && r_compare != '0) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_ti      = r_ti;
  assign w_count   = r_count;
  assign w_compare = r_compare;
  `else
  assign w_ti      = 1'b0;
  assign w_count   = '0;
  assign w_compare = '0;
  `endif

  assign w_ip    = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
  assign w_cause = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

  assign w_int_req  = inst_valid_i & r_status[0] & ~r_status[1] & (|(w_ip & r_status[15:8]));
  assign w_exc_take = inst_valid_i & (w_int_req | (|exc_flags_i));
  assign w_eret     = eret_i & inst_valid_i & ~w_exc_take;
  assign w_mtc0     = write_en_i & ~w_exc_take;

  // Fixed-priority exception encoder; interrupts outrank every synchronous cause.
  always_comb begin
    w_exccode = EC_INT;
    w_bad_sel = BAD_NONE;
    if (w_int_req) begin
      w_exccode = EC_INT;
    end else if (exc_flags_i[6]) begin
      w_exccode = EC_ADEL;
      w_bad_sel = BAD_PC;
    end else if (exc_flags_i[5]) begin
      w_exccode = EC_RI;
    end else if (exc_flags_i[4]) begin
      w_exccode = EC_OV;
    end else if (exc_flags_i[3]) begin
      w_exccode = EC_SYS;
    end else if (exc_flags_i[2]) begin
      w_exccode = EC_BP;
    end else if (exc_flags_i[1]) begin
      w_exccode = EC_ADEL;
      w_bad_sel = BAD_DATA;
    end else if (exc_flags_i[0]) begin
      w_exccode = EC_ADES;
      w_bad_sel = BAD_DATA;
    end
  end

  assign flush_o     = rst & (w_exc_take | w_eret);
  assign flush_pc_o  = w_exc_take ? EXC_VECTOR : r_epc;
  assign epc_o       = r_epc;
  assign timer_int_o = w_ti;

  // mfc0 read path returns pre-edge register contents.
  always_comb begin
    read_data_o = '0;
    if (rst) begin
      case (read_addr_i)
        REG_BADVADDR: read_data_o = r_badvaddr;
        REG_COUNT:    read_data_o = w_count;
        REG_COMPARE:  read_data_o = w_compare;
        REG_STATUS:   read_data_o = r_status;
        REG_CAUSE:    read_data_o = w_cause;
        REG_EPC:      read_data_o = r_epc;
        default:      read_data_o = '0;
      endcase
    end
  end

  // Exception entry has precedence over eret and mtc0; EPC/BD frozen while EXL is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_status   <= STATUS_RST;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
    end else begin
      r_ip_hw <= w_hw_pad;
      if (w_exc_take) begin
        r_exccode <= w_exccode;
        if (!r_status[1]) begin
          r_epc <= delayslot_i ? (pc_i - DW'(4)) : pc_i;
          r_bd  <= delayslot_i;
        end
        r_status[1] <= 1'b1;
        case (w_bad_sel)
          BAD_PC:   r_badvaddr <= pc_i;
          BAD_DATA: r_badvaddr <= badaddr_i;
          default:  ;
        endcase
      end else begin
        if (w_eret) begin
          r_status[1] <= 1'b0;
        end
        if (w_mtc0) begin
          case (write_addr_i)
            REG_STATUS: if (!w_eret) r_status <= write_data_i & STATUS_WMASK;
            REG_CAUSE:  r_ip_sw <= write_data_i[9:8];
            REG_EPC:    r_epc   <= write_data_i;
            default:    ;
          endcase
        end
      end
    end
  end

endmodule
